// File: rtl/rstseq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rstseq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        LOCK_FILT,
        RELEASE,
        RUN,
        HOLD
    } rstseq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rstseq_syncreg.sv
// Multi-flop synchroniser for a single asynchronous level; resets and powers up to INIT.
module syncreg #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q = {STAGES{INIT}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= {STAGES{INIT}};
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d};
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/rstseq.sv
// Lock-qualified reset sequencer: releases N_OUT reset domains in order, STAGE_DELAY
// cycles apart, once the clock source has been stably locked for LOCK_CYCLES cycles.
module rstseq
    import rstseq_pkg::*;
#(
    parameter int N_OUT       = 4,
    parameter int STAGE_DELAY = 16,
    parameter int LOCK_CYCLES = 8,
    parameter int SYNC_LOCK   = 1
) (
    input  logic             clk,
    input  logic             rstin,
    input  logic             clklock,
    input  logic             sw_rst_req,
    output logic [N_OUT-1:0] rstout,
    output logic             seq_done,
    output logic             lock_lost
);

    localparam int CNT_W = $clog2(max_int(STAGE_DELAY, LOCK_CYCLES) + 1);
    localparam int STG_W = $clog2(N_OUT + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [STG_W-1:0] STG_LAST   = STG_W'(N_OUT - 1);

    logic lock_s;

    generate
        if (SYNC_LOCK != 0) begin : g_lock_sync
            syncreg #(
                .STAGES(2),
                .INIT  (1'b0)
            ) u_lock_sync (
                .clk  (clk),
                .rst_n(rstin),
                .d    (clklock),
                .q    (lock_s)
            );
        end else begin : g_lock_direct
            assign lock_s = clklock;
        end
    endgenerate

    // Power-up values match the reset values so domains are held from configuration.
    rstseq_state_t    state_q = WAIT_LOCK;
    logic [CNT_W-1:0] cnt_q   = '0;
    logic [STG_W-1:0] stg_q   = '0;
    logic [N_OUT-1:0] rst_q   = '1;
    logic             done_q  = 1'b0;
    logic             lost_q  = 1'b0;

    always_ff @(posedge clk or negedge rstin) begin
        if (!rstin) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            stg_q   <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    rst_q  <= '1;
                    done_q <= 1'b0;
                    if (lock_s) begin
                        state_q <= LOCK_FILT;
                        cnt_q   <= '0;
                    end
                end
                LOCK_FILT: begin
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
                        stg_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RELEASE, RUN: begin
                    // Lock loss outranks a software request and keeps the sticky flag set.
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                        rst_q   <= '1;
                        done_q  <= 1'b0;
                        lost_q  <= 1'b1;
                        cnt_q   <= '0;
                        stg_q   <= '0;
                    end else if (sw_rst_req) begin
                        state_q <= HOLD;
                        rst_q   <= '1;
                        done_q  <= 1'b0;
                        lost_q  <= 1'b0;
                        cnt_q   <= '0;
                        stg_q   <= '0;
                    end else if (state_q == RELEASE) begin
                        if (cnt_q == STAGE_LAST) begin
                            cnt_q <= '0;
                            for (int k = 0; k < N_OUT; k++) begin
                                if (stg_q == STG_W'(k)) rst_q[k] <= 1'b0;
                            end
                            if (stg_q == STG_LAST) begin
                                state_q <= RUN;
                                done_q  <= 1'b1;
                            end else begin
                                stg_q <= stg_q + STG_W'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == STAGE_LAST) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= WAIT_LOCK;
                    cnt_q   <= '0;
                    stg_q   <= '0;
                    rst_q   <= '1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rstout    = rst_q;
    assign seq_done  = done_q;
    assign lock_lost = lost_q;

endmodule

// File: tb/tb_rstseq.sv
// Self-checking bench for rstseq: directed scenarios plus randomized lock/software-reset traffic.
module tb_rstseq;

    localparam int N_OUT       = 4;
    localparam int STAGE_DELAY = 4;
    localparam int LOCK_CYCLES = 3;

    logic             clk        = 1'b0;
    logic             rstin      = 1'b0;
    logic             clklock    = 1'b0;
    logic             sw_rst_req = 1'b0;
    logic [N_OUT-1:0] rstout;
    logic             seq_done;
    logic             lock_lost;

    int checks   = 0;
    int failures = 0;

    // Reference model: edge count, edge of first lock sample (-1 = waiting),
    // edge on which a software hold ends (-1 = none), sticky loss flag.
    int m_edge     = 0;
    int m_start    = -1;
    int m_hold_end = -1;
    bit m_lost     = 1'b0;

    rstseq #(
        .N_OUT      (N_OUT),
        .STAGE_DELAY(STAGE_DELAY),
        .LOCK_CYCLES(LOCK_CYCLES),
        .SYNC_LOCK  (0)
    ) dut (
        .clk       (clk),
        .rstin     (rstin),
        .clklock   (clklock),
        .sw_rst_req(sw_rst_req),
        .rstout    (rstout),
        .seq_done  (seq_done),
        .lock_lost (lock_lost)
    );

    always #5 clk = ~clk;

    function automatic logic [N_OUT-1:0] exp_rstout();
        logic [N_OUT-1:0] r;
        r = '1;
        if (m_start >= 0) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (m_edge >= m_start + LOCK_CYCLES + (k + 1) * STAGE_DELAY) r[k] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [N_OUT+1:0] exp_vec();
        logic [N_OUT-1:0] r;
        r = exp_rstout();
        return {r, (r == '0), m_lost};
    endfunction

    task automatic model_reset();
        m_start    = -1;
        m_hold_end = -1;
        m_lost     = 1'b0;
    endtask

    task automatic model_edge(input bit lock, input bit sw);
        m_edge++;
        if (m_hold_end >= 0) begin
            if (m_edge == m_hold_end) m_hold_end = -1;
        end else if (m_start < 0) begin
            if (lock) m_start = m_edge;
        end else if (m_edge - m_start <= LOCK_CYCLES) begin
            if (!lock) m_start = -1;
        end else begin
            if (!lock) begin
                m_lost  = 1'b1;
                m_start = -1;
            end else if (sw) begin
                m_lost     = 1'b0;
                m_start    = -1;
                m_hold_end = m_edge + STAGE_DELAY;
            end
        end
    endtask

    task automatic cycle(input bit lock, input bit sw);
        clklock    = lock;
        sw_rst_req = sw;
        @(posedge clk);
        model_edge(lock, sw);
        #1;
    endtask

    task automatic do_reset();
        #2 rstin = 1'b0;
        model_reset();
        @(posedge clk);
        #2 rstin = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({rstout, seq_done, lock_lost} !== {4'hF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_initial: got %b expected %b", {rstout, seq_done, lock_lost}, {4'hF, 2'b00});
        end
        clklock = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({rstout, seq_done, lock_lost} !== {4'hF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_held: got %b expected %b", {rstout, seq_done, lock_lost}, {4'hF, 2'b00});
        end
        clklock = 1'b0;
        #1 rstin = 1'b1;
    endtask

    task automatic test_sequence();
        int e0;
        do_reset();
        e0 = -1;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 1'b0);
            if (e0 < 0) e0 = m_edge;
            checks++;
            if ({rstout, seq_done, lock_lost} !== exp_vec()) begin
                failures++;
                $display("FAIL sequence t=%0d: got %b expected %b", m_edge - e0, {rstout, seq_done, lock_lost}, exp_vec());
            end
            if (m_edge - e0 == 19) begin
                checks++;
                if ({rstout, seq_done} !== {4'h0, 1'b1}) begin
                    failures++;
                    $display("FAIL sequence_done_e0+19: got %b expected %b", {rstout, seq_done}, 5'b00001);
                end
            end
        end
    endtask

    task automatic test_filter_abort();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(i < 2, 1'b0);
            checks++;
            if ({rstout, seq_done, lock_lost} !== exp_vec()) begin
                failures++;
                $display("FAIL filter_abort i=%0d: got %b expected %b", i, {rstout, seq_done, lock_lost}, exp_vec());
            end
        end
        checks++;
        if ({rstout, lock_lost} !== {4'hF, 1'b0}) begin
            failures++;
            $display("FAIL filter_abort_final: got %b expected %b", {rstout, lock_lost}, 5'b11110);
        end
    endtask

    task automatic test_lock_loss();
        do_reset();
        for (int i = 0; i < 45; i++) begin
            cycle(!(i >= 14 && i < 17), 1'b0);
            checks++;
            if ({rstout, seq_done, lock_lost} !== exp_vec()) begin
                failures++;
                $display("FAIL lock_loss i=%0d: got %b expected %b", i, {rstout, seq_done, lock_lost}, exp_vec());
            end
            if (i == 14) begin
                checks++;
                if ({rstout, lock_lost} !== {4'hF, 1'b1}) begin
                    failures++;
                    $display("FAIL lock_loss_flag: got %b expected %b", {rstout, lock_lost}, 5'b11111);
                end
            end
        end
    endtask

    task automatic test_sw_rst();
        do_reset();
        for (int i = 0; i < 52; i++) begin
            cycle(1'b1, i == 22);
            checks++;
            if ({rstout, seq_done, lock_lost} !== exp_vec()) begin
                failures++;
                $display("FAIL sw_rst i=%0d: got %b expected %b", i, {rstout, seq_done, lock_lost}, exp_vec());
            end
            if (i == 22) begin
                checks++;
                if ({rstout, seq_done, lock_lost} !== {4'hF, 1'b0, 1'b0}) begin
                    failures++;
                    $display("FAIL sw_rst_assert: got %b expected %b", {rstout, seq_done, lock_lost}, 6'b111100);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            cycle(!(i == 22 || i == 23), i == 22);
            checks++;
            if ({rstout, seq_done, lock_lost} !== exp_vec()) begin
                failures++;
                $display("FAIL sw_and_loss i=%0d: got %b expected %b", i, {rstout, seq_done, lock_lost}, exp_vec());
            end
            if (i == 22) begin
                checks++;
                if ({rstout, lock_lost} !== {4'hF, 1'b1}) begin
                    failures++;
                    $display("FAIL sw_and_loss_priority: got %b expected %b", {rstout, lock_lost}, 5'b11111);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            cycle(i != 8, 1'b0);
            checks++;
            if ({rstout, seq_done, lock_lost} !== exp_vec()) begin
                failures++;
                $display("FAIL async_pre i=%0d: got %b expected %b", i, {rstout, seq_done, lock_lost}, exp_vec());
            end
        end
        #2 rstin = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({rstout, seq_done, lock_lost} !== {4'hF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset_immediate: got %b expected %b", {rstout, seq_done, lock_lost}, 6'b111100);
        end
        @(posedge clk);
        #2 rstin = 1'b1;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if ({rstout, seq_done, lock_lost} !== exp_vec()) begin
                failures++;
                $display("FAIL async_restart i=%0d: got %b expected %b", i, {rstout, seq_done, lock_lost}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit lock;
        bit sw;
        lock = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) lock = !lock;
            sw = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 rstin = 1'b0;
                model_reset();
                #1;
                checks++;
                if ({rstout, seq_done, lock_lost} !== exp_vec()) begin
                    failures++;
                    $display("FAIL random_async i=%0d: got %b expected %b", i, {rstout, seq_done, lock_lost}, exp_vec());
                end
                @(posedge clk);
                #2 rstin = 1'b1;
            end
            cycle(lock, sw);
            checks++;
            if ({rstout, seq_done, lock_lost} !== exp_vec()) begin
                failures++;
                $display("FAIL random i=%0d: got %b expected %b", i, {rstout, seq_done, lock_lost}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_filter_abort();
        test_lock_loss();
        test_sw_rst();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
